// File: rtl/clock_sequencer_pkg.sv
// Shared types and defaults for the core clock sequencer: FSM encoding, timing
// defaults and the button index map used by the debouncer bank.
package clock_sequencer_pkg;

    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT   = 1000000;
    localparam int unsigned DEBOUNCE_CYCLES_SIM       = 4;
    localparam int unsigned RESET_HOLD_CYCLES_DEFAULT = 16;

    localparam int unsigned NUM_BUTTONS = 4;
    localparam int unsigned BTN_RESET   = 0;
    localparam int unsigned BTN_FREQ    = 1;
    localparam int unsigned BTN_MODE    = 2;
    localparam int unsigned BTN_STEP    = 3;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RUN       = 2'd2
    } seq_state_e;

endpackage

// File: rtl/clock_sequencer_if.sv
// Board-side inputs and clock-subsystem controls of the sequencer.
// The master drives stimulus (buttons, lock, stall, tick); the slave is the sequencer.
interface clock_sequencer_if;
    logic pll_locked;
    logic reset_button;
    logic frequency_mode_button;
    logic clock_mode_button;
    logic manual_clock_button;
    logic stall_core;
    logic divided_tick;
    logic core_clock_enable;
    logic core_reset;
    logic manual_mode;
    logic slow_mode;
    logic running;

    modport master (
        output pll_locked, reset_button, frequency_mode_button, clock_mode_button,
               manual_clock_button, stall_core, divided_tick,
        input  core_clock_enable, core_reset, manual_mode, slow_mode, running
    );

    modport slave (
        input  pll_locked, reset_button, frequency_mode_button, clock_mode_button,
               manual_clock_button, stall_core, divided_tick,
        output core_clock_enable, core_reset, manual_mode, slow_mode, running
    );
endinterface

// File: rtl/clock_sequencer_button_debouncer.sv
// Two-flop synchronizer plus saturating stability counter for one raw button.
// Emits a registered one-cycle pulse when a new pressed level is accepted.
module button_debouncer
    import clock_sequencer_pkg::*;
#(
    parameter int unsigned CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic button_i,
    output logic press_o
);
    localparam int unsigned CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any sample equal to the accepted level restarts the count, so bounces never accumulate.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= LAST) begin
            level_d = sync2_q;
            cnt_d   = '0;
            press_d = sync2_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            press_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= button_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            press_q <= press_d;
            cnt_q   <= cnt_d;
        end
    end

    assign press_o = press_q;
endmodule

// File: rtl/clock_sequencer.sv
// Core clock sequencer: lock/reset-hold FSM, mode flags, pending single step
// and the registered core clock enable mux.
module clock_sequencer
    import clock_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES   = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned RESET_HOLD_CYCLES = RESET_HOLD_CYCLES_DEFAULT
) (
    input  logic             clock_100mhz,
    input  logic             reset_n,
    clock_sequencer_if.slave bus
);
    localparam int unsigned HCW = $clog2(RESET_HOLD_CYCLES + 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RESET_HOLD_CYCLES - 1);

    logic [NUM_BUTTONS-1:0] raw_buttons;
    logic [NUM_BUTTONS-1:0] presses;

    assign raw_buttons[BTN_RESET] = bus.reset_button;
    assign raw_buttons[BTN_FREQ]  = bus.frequency_mode_button;
    assign raw_buttons[BTN_MODE]  = bus.clock_mode_button;
    assign raw_buttons[BTN_STEP]  = bus.manual_clock_button;

    generate
        for (genvar gi = 0; gi < NUM_BUTTONS; gi++) begin : g_btn
            button_debouncer #(.CYCLES(DEBOUNCE_CYCLES)) u_deb (
                .clk      (clock_100mhz),
                .rst_n    (reset_n),
                .button_i (raw_buttons[gi]),
                .press_o  (presses[gi])
            );
        end
    endgenerate

    logic           lock_sync1_q, lock_sync2_q;
    seq_state_e     state_q, state_d;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           manual_q, manual_d;
    logic           slow_q, slow_d;
    logic           pend_q, pend_d;
    logic           en_q, en_d;
    logic           core_reset_q, core_reset_d;
    logic           running_q, running_d;

    logic run_next, toggle, step_req, go;

    // Lock loss outranks everything; a reset press in HOLD simply restarts the count.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        if (!lock_sync2_q) begin
            state_d    = WAIT_LOCK;
            hold_cnt_d = '0;
        end else begin
            case (state_q)
                WAIT_LOCK: begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
                HOLD: begin
                    if (presses[BTN_RESET]) begin
                        hold_cnt_d = '0;
                    end else if (hold_cnt_q == HOLD_LAST) begin
                        state_d = RUN;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (presses[BTN_RESET]) begin
                        state_d    = HOLD;
                        hold_cnt_d = '0;
                    end
                end
                default: begin
                    state_d    = WAIT_LOCK;
                    hold_cnt_d = '0;
                end
            endcase
        end
    end

    // Enable uses the flags as they stand this cycle; toggles take effect next cycle.
    always_comb begin
        run_next     = (state_d == RUN);
        toggle       = presses[BTN_FREQ] | presses[BTN_MODE];
        step_req     = manual_q & presses[BTN_STEP];
        go           = run_next & ~bus.stall_core;
        manual_d     = manual_q ^ presses[BTN_MODE];
        slow_d       = slow_q ^ presses[BTN_FREQ];
        core_reset_d = ~run_next;
        running_d    = run_next;
        pend_d       = pend_q;

        if (manual_q) begin
            en_d = go & (step_req | pend_q);
        end else if (slow_q) begin
            en_d = go & bus.divided_tick;
        end else begin
            en_d = go;
        end

        if (toggle || !run_next) begin
            pend_d = 1'b0;
        end else if (manual_q && bus.stall_core && step_req) begin
            pend_d = 1'b1;
        end else if (manual_q && en_d) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clock_100mhz or negedge reset_n) begin
        if (!reset_n) begin
            lock_sync1_q <= 1'b0;
            lock_sync2_q <= 1'b0;
            state_q      <= WAIT_LOCK;
            hold_cnt_q   <= '0;
            manual_q     <= 1'b0;
            slow_q       <= 1'b0;
            pend_q       <= 1'b0;
            en_q         <= 1'b0;
            core_reset_q <= 1'b1;
            running_q    <= 1'b0;
        end else begin
            lock_sync1_q <= bus.pll_locked;
            lock_sync2_q <= lock_sync1_q;
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            manual_q     <= manual_d;
            slow_q       <= slow_d;
            pend_q       <= pend_d;
            en_q         <= en_d;
            core_reset_q <= core_reset_d;
            running_q    <= running_d;
        end
    end

    assign bus.core_clock_enable = en_q;
    assign bus.core_reset        = core_reset_q;
    assign bus.manual_mode       = manual_q;
    assign bus.slow_mode         = slow_q;
    assign bus.running           = running_q;
endmodule
